// File: rtl/srl_tap_sequencer.sv
// Sample-buffer sequencer for an 18x32 SRLC32E FIR delay line: shifts each strobed sample
// in, then sweeps taps 0..len newest-first. Optional SRL_OVR_COUNT_EN adds ovr_cnt/ovr_clr.
module srl_tap_sequencer #(
    parameter int W  = 18,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  din,
    input  logic          dstb,
    input  logic [AW-1:0] len,
    output logic [W-1:0]  sr_d,
    output logic          sr_ce,
    output logic [AW-1:0] sr_a,
    input  logic [W-1:0]  sr_y,
    output logic [W-1:0]  tap,
    output logic          tvld,
    output logic          tfirst,
    output logic          tlast,
    output logic          busy,
    output logic          ovr
`ifdef SRL_OVR_COUNT_EN
   ,input  logic          ovr_clr,
    output logic [7:0]    ovr_cnt
`endif
);

    // state | meaning
    // IDLE  | waiting for a strobe or a pending sample; shift happens here
    // SWEEP | presenting addresses 0..ln to the delay line, one per cycle
    typedef enum logic {IDLE, SWEEP} state_t;

    state_t        state, state_nx;
    logic          pend, pend_nx;
    logic [W-1:0]  pdat, pdat_nx;
    logic [AW-1:0] addr, addr_nx;
    logic [AW-1:0] ln, ln_nx;
    logic          drop;

    always_comb begin
        state_nx = state;
        pend_nx  = pend;
        pdat_nx  = pdat;
        addr_nx  = addr;
        ln_nx    = ln;
        sr_d     = din;
        sr_ce    = 1'b0;
        sr_a     = '0;
        drop     = 1'b0;
        case (state)
            IDLE: begin
                if (pend) begin
                    sr_d     = pdat;
                    sr_ce    = 1'b1;
                    ln_nx    = len;
                    state_nx = SWEEP;
                    addr_nx  = '0;
                    if (dstb) pdat_nx = din;
                    else      pend_nx = 1'b0;
                end else if (dstb) begin
                    sr_ce    = 1'b1;
                    ln_nx    = len;
                    state_nx = SWEEP;
                    addr_nx  = '0;
                end
            end
            SWEEP: begin
                sr_a = addr;
                if (addr == ln) begin
                    state_nx = IDLE;
                    addr_nx  = '0;
                end else begin
                    addr_nx = addr + 1'b1;
                end
                // One-deep holding slot; a second arrival during the sweep is lost
                if (dstb) begin
                    if (!pend) begin
                        pdat_nx = din;
                        pend_nx = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (rst) begin
            sr_ce = 1'b0;
            sr_a  = '0;
            drop  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pend  <= 1'b0;
            pdat  <= '0;
            addr  <= '0;
            ln    <= '0;
        end else begin
            state <= state_nx;
            pend  <= pend_nx;
            pdat  <= pdat_nx;
            addr  <= addr_nx;
            ln    <= ln_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tap    <= '0;
            tvld   <= 1'b0;
            tfirst <= 1'b0;
            tlast  <= 1'b0;
        end else if (state == SWEEP) begin
            tap    <= sr_y;
            tvld   <= 1'b1;
            tfirst <= (addr == '0);
            tlast  <= (addr == ln);
        end else begin
            tvld   <= 1'b0;
            tfirst <= 1'b0;
            tlast  <= 1'b0;
        end
    end

    assign ovr  = drop;
    assign busy = (state == SWEEP) | pend;

`ifdef SRL_OVR_COUNT_EN
    // A clear coinciding with a drop leaves that drop counted
    always_ff @(posedge clk) begin
        if (rst)
            ovr_cnt <= '0;
        else if (ovr_clr)
            ovr_cnt <= {7'd0, drop};
        else if (drop && ovr_cnt != 8'hff)
            ovr_cnt <= ovr_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_srl_tap_sequencer.sv
// Bench for srl_tap_sequencer: behavioural SRL model plus a tap scoreboard filled
// when samples are strobed and drained whenever tvld is seen.
module tb_srl_tap_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] din = '0;
    logic        dstb = 1'b0;
    logic [4:0]  len = '0;
    logic [17:0] sr_d, sr_y, tap;
    logic        sr_ce, tvld, tfirst, tlast, busy, ovr;
    logic [4:0]  sr_a;
`ifdef SRL_OVR_COUNT_EN
    logic        ovr_clr = 1'b0;
    logic [7:0]  ovr_cnt;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [17:0] t;
        logic        f;
        logic        l;
    } exp_t;
    exp_t        exp_q[$];
    logic [17:0] hist[$];
    logic [17:0] srl[32];
    logic        ovr_exp = 1'b0;
    bit          found;

    srl_tap_sequencer dut (
        .clk(clk), .rst(rst), .din(din), .dstb(dstb), .len(len),
        .sr_d(sr_d), .sr_ce(sr_ce), .sr_a(sr_a), .sr_y(sr_y),
        .tap(tap), .tvld(tvld), .tfirst(tfirst), .tlast(tlast),
        .busy(busy), .ovr(ovr)
`ifdef SRL_OVR_COUNT_EN
       ,.ovr_clr(ovr_clr), .ovr_cnt(ovr_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(input string tag, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $error("FAIL %s", tag);
        end
    endfunction

    initial for (int i = 0; i < 32; i++) srl[i] = '0;
    always @(posedge clk) begin
        if (sr_ce) begin
            for (int i = 31; i > 0; i--) srl[i] <= srl[i-1];
            srl[0] <= sr_d;
        end
    end
    assign sr_y = srl[sr_a];

    always @(negedge clk) begin
        chk("ovr_pulse", ovr === ovr_exp);
        if (tvld) begin
            chk("tvld_expected", exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("tap", tap === e.t);
                chk("tfirst", tfirst === e.f);
                chk("tlast", tlast === e.l);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        dstb    = 1'b0;
        ovr_exp = 1'b0;
    endtask

    // Drives a strobe in the current cycle; kept=1 means the sample will be swept
    task automatic strobe(input logic [17:0] d, input bit kept);
        din  = d;
        dstb = 1'b1;
        if (kept) begin
            hist.push_front(d);
            for (int i = 0; i <= int'(len); i++)
                exp_q.push_back('{hist[i], (i == 0), (i == int'(len))});
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) hist.push_back('0);

        repeat (3) cyc();
        rst = 1'b0;
        repeat (10) cyc();
        #1;
        chk("idle_sr_ce", sr_ce === 1'b0);
        chk("idle_tvld", tvld === 1'b0);
        chk("idle_busy", busy === 1'b0);
        chk("idle_sr_a", sr_a === 5'd0);

        // Single sweep, len=3
        len = 5'd3;
        cyc();
        strobe(18'h00011, 1'b1);
        #1;
        chk("t2_sr_ce", sr_ce === 1'b1);
        chk("t2_sr_d", sr_d === 18'h00011);
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            chk("t2_sr_a", sr_a === 5'(k));
            chk("t2_sweep_ce", sr_ce === 1'b0);
            chk("t2_busy", busy === 1'b1);
        end
        cyc();
        #1;
        chk("t2_tlast_T5", tlast === 1'b1);
        chk("t2_tvld_T5", tvld === 1'b1);
        chk("t2_idle_sr_a", sr_a === 5'd0);
        chk("t2_idle_busy", busy === 1'b0);
        cyc();
        #1;
        chk("t2_tvld_T6", tvld === 1'b0);

        // Four samples, 6-cycle spacing
        for (int s = 1; s <= 4; s++) begin
            cyc();
            strobe(18'(s), 1'b1);
            repeat (5) cyc();
        end
        repeat (2) cyc();

        // Held sample, len=7
        len = 5'd7;
        cyc();
        strobe(18'h000a1, 1'b1);
        cyc();
        cyc();
        strobe(18'h000a2, 1'b1);
        cyc();
        #1;
        chk("t4_busy_pend", busy === 1'b1);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            #1;
            if (tvld && tlast) found = 1'b1;
            else cyc();
        end
        chk("t4_tlast_found", found === 1'b1);
        chk("t4_pend_shift_ce", sr_ce === 1'b1);
        chk("t4_pend_shift_d", sr_d === 18'h000a2);
        repeat (12) cyc();

        // Overrun: three back-to-back strobes
        cyc();
        strobe(18'h000b1, 1'b1);
        cyc();
        strobe(18'h000b2, 1'b1);
        cyc();
        strobe(18'h000b3, 1'b0);
        ovr_exp = 1'b1;
        #1;
        chk("t5_ovr", ovr === 1'b1);
        repeat (22) cyc();
        #1;
        chk("t5_busy_done", busy === 1'b0);
`ifdef SRL_OVR_COUNT_EN
        chk("t5_ovr_cnt", ovr_cnt === 8'd1);
`endif

        // Reset mid-sweep
        cyc();
        strobe(18'h000c1, 1'b1);
        cyc();
        cyc();
        cyc();
        #1;
        chk("t6_sr_a_2", sr_a === 5'd2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_tvld_after_rst", tvld === 1'b0);
        chk("t6_busy_after_rst", busy === 1'b0);
`ifdef SRL_OVR_COUNT_EN
        chk("t6_ovr_cnt_rst", ovr_cnt === 8'd0);
`endif
        repeat (3) cyc();
        strobe(18'h000c2, 1'b1);
        cyc();
        #1;
        chk("t6_restart_sr_a", sr_a === 5'd0);
        cyc();
        #1;
        chk("t6_restart_tfirst", tfirst === 1'b1);
        repeat (12) cyc();
        #1;
        chk("end_queue_empty", exp_q.size() == 0);
        chk("end_busy", busy === 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: observed running expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
